fp_adder: RTL and testbench



---
 rtl/fp_adder_if.sv | 10 +
 rtl/fp_adder.sv | 179 +++++++++++++++++
 tb/tb_fp_adder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fp_adder_if.sv
// Operand/result bundle for the binary16 adder: the master drives both operands
// and the slave returns the packed sum.
interface fp_adder_if;
    logic [15:0] input_1_80;
    logic [15:0] input_2_80;
    logic [15:0] sum_80;

    modport master (output input_1_80, output input_2_80, input sum_80);
    modport slave  (input input_1_80, input input_2_80, output sum_80);
endinterface

// File: rtl/fp_adder.sv
// Pipelined IEEE-754 binary16 adder; round-to-nearest-even when FP_ADDER_RNE_EN is defined, else truncation.
// Latency 4 cycles: operands are registered through four stages, and the sum changes after the fourth register.
// No backpressure: one operand pair is accepted on every clock edge.
module fp_adder (
    input  logic      clock_80,
    input  logic      reset_n_80,
    fp_adder_if.slave bus
);
`ifdef FP_ADDER_RNE_EN
    localparam int XB = 3;
`else
    localparam int XB = 0;
`endif
    // Mantissa width = hidden bit + 10 fraction bits + any guard/round/sticky bits.
    localparam int MW = 11 + XB;

    function automatic logic [3:0] lzc(input logic [MW-1:0] v);
        lzc = 4'(MW);
        for (int i = 0; i < MW; i++)
            if (v[i]) lzc = 4'(MW - 1 - i);
    endfunction

    logic [15:0] op_a, op_b;
    assign op_a = bus.input_1_80;
    assign op_b = bus.input_2_80;

    // S1: unpack, order by magnitude, exponent difference, special cases.
    logic        a_big, spec_c;
    logic [15:0] spec_val_c;
    logic [4:0]  a_e, b_e;
    logic [10:0] a_m, b_m;

    always_comb begin
        a_e        = op_a[14:10];
        b_e        = op_b[14:10];
        a_m        = {a_e != 5'd0, op_a[9:0]};
        b_m        = {b_e != 5'd0, op_b[9:0]};
        a_big      = op_a[14:0] >= op_b[14:0];
        spec_c     = 1'b1;
        spec_val_c = 16'h0000;
        if (a_e == 5'h1F && b_e == 5'h1F && op_a[15] != op_b[15])
            spec_val_c = 16'h7E00;
        else if (a_e == 5'h1F)
            spec_val_c = {op_a[15], 5'h1F, 10'h000};
        else if (b_e == 5'h1F)
            spec_val_c = {op_b[15], 5'h1F, 10'h000};
        else if (a_e == 5'd0 && b_e == 5'd0)
            spec_val_c = 16'h0000;
        else if (a_e == 5'd0)
            spec_val_c = op_b;
        else if (b_e == 5'd0)
            spec_val_c = op_a;
        else
            spec_c = 1'b0;
    end

    logic        s1_sign, s1_sub, s1_spec;
    logic [4:0]  s1_exp, s1_d;
    logic [10:0] s1_mb, s1_ms;
    logic [15:0] s1_spec_val;

    // S2: align the smaller mantissa and add/subtract.
    logic [4:0]     sh;
    logic [MW-1:0]  big_x, small_x, aligned;
    logic [MW+13:0] wide;
    logic [MW:0]    sum_c;

    always_comb begin
        sh      = (s1_d > 5'd14) ? 5'd14 : s1_d;
        big_x   = MW'(s1_mb) << XB;
        small_x = MW'(s1_ms) << XB;
        wide    = {small_x, 14'b0} >> sh;
        aligned = wide[MW+13:14];
`ifdef FP_ADDER_RNE_EN
        aligned[0] = aligned[0] | (|wide[13:0]);
`endif
        sum_c = s1_sub ? ({1'b0, big_x} - {1'b0, aligned})
                       : ({1'b0, big_x} + {1'b0, aligned});
    end

    logic            s2_sign, s2_spec;
    logic [4:0]      s2_exp;
    logic [MW:0]     s2_sum;
    logic [15:0]     s2_spec_val;

    // S3: normalize right on carry-out, else left by the leading-zero count.
    logic [3:0]    lz;
    logic [MW-1:0] norm_c;
    logic [6:0]    exp_c;

    always_comb begin
        lz = lzc(s2_sum[MW-1:0]);
        if (s2_sum[MW]) begin
            norm_c = s2_sum[MW:1];
`ifdef FP_ADDER_RNE_EN
            norm_c[0] = s2_sum[1] | s2_sum[0];
`endif
            exp_c = {2'b00, s2_exp} + 7'd1;
        end else begin
            norm_c = s2_sum[MW-1:0] << lz;
            exp_c  = {2'b00, s2_exp} - {3'b000, lz};
        end
    end

    logic          s3_sign, s3_zero, s3_spec;
    logic [6:0]    s3_exp;
    logic [MW-1:0] s3_norm;
    logic [15:0]   s3_spec_val;

    // S4: round, renormalize on rounding carry, range-check and pack.
    logic        up;
    logic [11:0] m_rnd, m_fin;
    logic [6:0]  e_fin;
    logic [15:0] res_c;
    logic        unused_bits;

    always_comb begin
        up = 1'b0;
`ifdef FP_ADDER_RNE_EN
        up = s3_norm[2] & (s3_norm[1] | s3_norm[0] | s3_norm[3]);
`endif
        m_rnd = {1'b0, s3_norm[MW-1:XB]} + {11'b0, up};
        m_fin = m_rnd;
        e_fin = s3_exp;
        if (m_rnd[11]) begin
            m_fin = m_rnd >> 1;
            e_fin = s3_exp + 7'd1;
        end
        if (s3_spec)
            res_c = s3_spec_val;
        else if (s3_zero)
            res_c = 16'h0000;
        else if (e_fin[6] || e_fin == 7'd0)
            res_c = {s3_sign, 15'h0000};
        else if (e_fin >= 7'd31)
            res_c = {s3_sign, 5'h1F, 10'h000};
        else
            res_c = {s3_sign, e_fin[4:0], m_fin[9:0]};
    end

    assign unused_bits = ^{m_fin[11:10], wide[13:0]};

    logic [15:0] sum_q;

    always_ff @(posedge clock_80) begin
        if (!reset_n_80) begin
            s1_sign <= 1'b0;  s1_sub <= 1'b0;  s1_spec <= 1'b0;  s1_exp <= '0;
            s1_d    <= '0;    s1_mb  <= '0;    s1_ms   <= '0;    s1_spec_val <= '0;
            s2_sign <= 1'b0;  s2_spec <= 1'b0; s2_exp <= '0;     s2_sum <= '0;
            s2_spec_val <= '0;
            s3_sign <= 1'b0;  s3_zero <= 1'b0; s3_spec <= 1'b0;  s3_exp <= '0;
            s3_norm <= '0;    s3_spec_val <= '0;
            sum_q   <= 16'h0000;
        end else begin
            s1_sign     <= a_big ? op_a[15] : op_b[15];
            s1_sub      <= op_a[15] ^ op_b[15];
            s1_exp      <= a_big ? a_e : b_e;
            s1_d        <= a_big ? (a_e - b_e) : (b_e - a_e);
            s1_mb       <= a_big ? a_m : b_m;
            s1_ms       <= a_big ? b_m : a_m;
            s1_spec     <= spec_c;
            s1_spec_val <= spec_val_c;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_sum      <= sum_c;
            s2_spec     <= s1_spec;
            s2_spec_val <= s1_spec_val;
            s3_sign     <= s2_sign;
            s3_exp      <= exp_c;
            s3_norm     <= norm_c;
            s3_zero     <= (s2_sum == '0);
            s3_spec     <= s2_spec;
            s3_spec_val <= s2_spec_val;
            sum_q       <= res_c;
        end
    end

    assign bus.sum_80 = sum_q;
endmodule

// File: tb/tb_fp_adder.sv
// Directed-vector bench for fp_adder: stimulus pushes expected sums into a
// scoreboard queue tagged with the cycle they are due; a monitor compares them.
module tb_fp_adder;
    logic clock_80   = 1'b0;
    logic reset_n_80 = 1'b0;

    fp_adder_if bus ();

    fp_adder dut (
        .clock_80   (clock_80),
        .reset_n_80 (reset_n_80),
        .bus        (bus)
    );

    always #5 clock_80 = ~clock_80;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clock_80) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

`ifdef FP_ADDER_RNE_EN
    localparam logic [15:0] RND_SUM = 16'h4002;
`else
    localparam logic [15:0] RND_SUM = 16'h4001;
`endif

    localparam int NV = 20;
    logic [15:0] va [NV] = '{16'h5620, 16'h56EE, 16'h5630, 16'hD6E2, 16'hD1A0,
                             16'hDC6C, 16'h0000, 16'h0000, 16'h3C03, 16'h5948,
                             16'h7BFF, 16'h7C00, 16'h7C00, 16'h3C00, 16'h3C00,
                             16'h8401, 16'h0001, 16'h7000, 16'h3C00, 16'h4000};
    logic [15:0] vb [NV] = '{16'h5948, 16'h5632, 16'hD590, 16'h563E, 16'h54F0,
                             16'hD420, 16'h0000, 16'hD750, 16'h3C00, 16'h5620,
                             16'h7BFF, 16'hFC00, 16'h3C00, 16'hFC00, 16'hBC00,
                             16'h0400, 16'h3C00, 16'h0400, 16'h0000, 16'h3C00};
    logic [15:0] ve [NV] = '{16'h5C2C, 16'h5A90, 16'h4900, 16'hC920, 16'h5040,
                             16'hDD74, 16'h0000, 16'hD750, RND_SUM,  16'h5C2C,
                             16'h7C00, 16'h7E00, 16'h7C00, 16'hFC00, 16'h0000,
                             16'h8000, 16'h3C00, 16'h7000, 16'h3C00, 16'h4200};

    task automatic expect_at(input int due, input logic [15:0] val, input string tag);
        exp_t e;
        e.due = due;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e, input string tag);
        bus.input_1_80 = a;
        bus.input_2_80 = b;
        expect_at(cyc + 4, e, tag);
    endtask

    // Monitor: compare the scoreboard head on the cycle it falls due.
    always @(negedge clock_80) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (bus.sum_80 !== e.val) begin
                errors++;
                $display("FAIL %s at cycle %0d: sum_80=%h expected=%h",
                         e.tag, cyc, bus.sum_80, e.val);
            end
        end
    end

    initial begin
        int budget;
        bus.input_1_80 = 16'h3C00;
        bus.input_2_80 = 16'h3C00;

        // Reset held for two edges with live operands on the inputs.
        repeat (2) begin
            @(negedge clock_80);
            expect_at(cyc + 1, 16'h0000, "reset_hold");
        end

        // Release: output stays zero until the first post-reset pair lands.
        @(negedge clock_80);
        reset_n_80 = 1'b1;
        for (int i = 1; i <= 3; i++) expect_at(cyc + i, 16'h0000, "post_reset_zero");
        issue(16'h3C00, 16'h3C00, 16'h4000, "first_latency");

        // Directed vectors, one per cycle.
        for (int i = 0; i < NV; i++) begin
            @(negedge clock_80);
            issue(va[i], vb[i], ve[i], $sformatf("vec%0d", i));
        end
        @(negedge clock_80);
        issue(16'h5630, 16'hD590, 16'h4900, "pre_reset_a");
        @(negedge clock_80);
        issue(16'hDC6C, 16'hD420, 16'hDD74, "pre_reset_b");

        // Mid-stream reset discards everything in flight.
        @(negedge clock_80);
        reset_n_80 = 1'b0;
        sb.delete();
        expect_at(cyc + 1, 16'h0000, "mid_reset");
        @(negedge clock_80);
        expect_at(cyc + 1, 16'h0000, "mid_reset_hold");
        @(negedge clock_80);
        reset_n_80 = 1'b1;
        for (int i = 1; i <= 3; i++) expect_at(cyc + i, 16'h0000, "flush_zero");
        issue(16'h5620, 16'h5948, 16'h5C2C, "after_reset");

        budget = 50;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clock_80);
            budget--;
        end
        @(posedge clock_80);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
